// File: rtl/acia_host_if.sv
// ACIA strobe/status signals and host RX/TX stream handshakes for acia_host.
interface acia_host_if;
    logic       mode_out;
    logic       read_out;
    logic       write_out;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       rx_ready_in;
    logic [7:0] tx_data_in;
    logic       tx_valid_in;
    logic       tx_ready_out;
    logic [7:0] status_out;

    modport master (
        output mode_out, read_out, write_out,
        output rx_data_out, rx_valid_out, tx_ready_out, status_out,
        input  rx_ready_in, tx_data_in, tx_valid_in
    );

    modport slave (
        input  mode_out, read_out, write_out,
        input  rx_data_out, rx_valid_out, tx_ready_out, status_out,
        output rx_ready_in, tx_data_in, tx_valid_in
    );
endinterface

// File: rtl/acia_host.sv
// ACIA bus initiator: programs control once, then polls status, drains RX
// bytes into a host stream and writes host TX bytes when the ACIA is ready.
module acia_host #(
    parameter logic [7:0]  CTRL_INIT = 8'h00,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned POLL_GAP  = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    acia_host_if.master host_if,
    inout  wire  [7:0]  bus_io
);
    localparam int unsigned CW      = 8;
    localparam int unsigned GAP_LEN = (POLL_GAP == 0) ? 1 : POLL_GAP;
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_INIT, S_GAP, S_STAT, S_RDAT, S_WDAT, S_SETL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_ready_q, tx_ready_d;
    logic [7:0]    status_q, status_d;

    // Strobes are registered copies of the access the next state performs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            read_q     <= read_d;
            write_q    <= write_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            status_q   <= status_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = 1'b0;
        read_d     = 1'b0;
        write_d    = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~host_if.rx_ready_in;
        tx_data_d  = tx_data_q;
        tx_ready_d = tx_ready_q;
        status_d   = status_q;

        if (tx_ready_q && host_if.tx_valid_in) begin
            tx_ready_d = 1'b0;
            tx_data_d  = host_if.tx_data_in;
        end

        case (state_q)
            // First INIT cycle is the reset-idle cycle; the second carries the write.
            S_INIT: begin
                if (!write_q) begin
                    write_d = 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_STAT;
                    read_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // RX has priority; RDRF is ignored while the host still holds a byte.
            S_STAT: begin
                status_d = bus_io;
                if (bus_io[0] && !rx_valid_q) begin
                    state_d = S_RDAT;
                    read_d  = 1'b1;
                    mode_d  = 1'b1;
                end else if (bus_io[1] && !tx_ready_q) begin
                    state_d = S_WDAT;
                    write_d = 1'b1;
                    mode_d  = 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_RDAT: begin
                rx_data_d  = bus_io;
                rx_valid_d = 1'b1;
                state_d    = S_GAP;
                cnt_d      = '0;
            end
            S_WDAT: begin
                tx_ready_d = 1'b1;
                state_d    = S_SETL;
                cnt_d      = '0;
            end
            S_SETL: begin
                if (cnt_q == SETL_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus_io = write_q ? ((state_q == S_INIT) ? CTRL_INIT : tx_data_q) : 8'hzz;

    assign host_if.mode_out     = mode_q;
    assign host_if.read_out     = read_q;
    assign host_if.write_out    = write_q;
    assign host_if.rx_data_out  = rx_data_q;
    assign host_if.rx_valid_out = rx_valid_q;
    assign host_if.tx_ready_out = tx_ready_q;
    assign host_if.status_out   = status_q;
endmodule

// File: tb/tb_acia_host.sv
// Bench for acia_host: ACIA device model plus a transaction-level predictor of
// the poll loop, checked every cycle, with directed and random host traffic.
module tb_acia_host;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned GAP_LEN = 1;
    localparam logic [7:0]  CTRL    = 8'h00;
    localparam int K_ANY = 0, K_CTRL = 1, K_STAT = 2, K_DRD = 3, K_DWR = 4;
    localparam int W_WRITE = 0, W_RXV = 1, W_DWR = 2, W_DACC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acia_host_if hif ();
    wire  [7:0] bus_w;
    logic [7:0] acia_st = 8'h00;
    logic [7:0] acia_rd = 8'h00;
    assign bus_w = hif.read_out ? (hif.mode_out ? acia_rd : acia_st) : 8'hzz;

    acia_host #(.CTRL_INIT(CTRL), .SETTLE(SETTLE), .POLL_GAP(0)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .host_if (hif),
        .bus_io  (bus_w)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ACIA device state: serial-line bytes consumed in order, TDRE busy timer.
    logic [7:0] line_bytes[$];
    int         line_idx   = 0;
    int         tdre_timer = 0;
    bit         rx_hold    = 1'b0;
    bit         tdre_hold  = 1'b0;

    // Host-visible expectations and the expected next bus access.
    logic       m_rxv, m_txr;
    logic [7:0] m_rxd, m_txd, m_stat;
    int         exp_kind, exp_idle, idle_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : cmp
        int         kind;
        logic       rdrf, tdre;
        logic [7:0] junk;
        logic       nrxv, ntxr;
        logic [7:0] nrxd, ntxd, nstat;
        forever begin
            @(negedge clk);
            rdrf    = !rx_hold && (line_idx < line_bytes.size());
            tdre    = !tdre_hold && (tdre_timer == 0);
            junk    = 8'($urandom);
            acia_st = {junk[7:2], tdre, rdrf};
            acia_rd = rdrf ? line_bytes[line_idx] : 8'hEE;
            if (rst) begin
                chk("rst_write", 32'(hif.write_out), 32'h0);
                chk("rst_read", 32'(hif.read_out), 32'h0);
                chk("rst_mode", 32'(hif.mode_out), 32'h0);
                chk("rst_rx_valid", 32'(hif.rx_valid_out), 32'h0);
                chk("rst_rx_data", 32'(hif.rx_data_out), 32'h0);
                chk("rst_tx_ready", 32'(hif.tx_ready_out), 32'h1);
                chk("rst_status", 32'(hif.status_out), 32'h0);
                m_rxv = 1'b0; m_rxd = 8'h00; m_txr = 1'b1; m_txd = 8'h00; m_stat = 8'h00;
                exp_kind = K_CTRL; exp_idle = 1; idle_cnt = 0;
                continue;
            end

            chk("rx_valid", 32'(hif.rx_valid_out), 32'(m_rxv));
            if (m_rxv) chk("rx_data", 32'(hif.rx_data_out), 32'(m_rxd));
            chk("tx_ready", 32'(hif.tx_ready_out), 32'(m_txr));
            chk("status", 32'(hif.status_out), 32'(m_stat));
            chk("rw_excl", 32'(hif.read_out & hif.write_out), 32'h0);

            nrxv = m_rxv; nrxd = m_rxd; ntxr = m_txr; ntxd = m_txd; nstat = m_stat;
            if (m_rxv && hif.rx_ready_in) nrxv = 1'b0;
            if (m_txr && hif.tx_valid_in) begin
                ntxr = 1'b0;
                ntxd = hif.tx_data_in;
            end

            kind = K_ANY;
            if (hif.read_out || hif.write_out) begin
                if (hif.write_out) kind = hif.mode_out ? K_DWR : K_CTRL;
                else               kind = hif.mode_out ? K_DRD : K_STAT;
                if (exp_kind != K_ANY) begin
                    chk("access_kind", 32'(kind), 32'(exp_kind));
                    chk("access_idle", 32'(idle_cnt), 32'(exp_idle));
                end
                idle_cnt = 0;
                case (kind)
                    K_CTRL: begin
                        chk("ctrl_bus", 32'(bus_w), 32'(CTRL));
                        exp_kind = K_STAT; exp_idle = GAP_LEN;
                    end
                    K_STAT: begin
                        nstat = acia_st;
                        if (acia_st[0] && !m_rxv) begin
                            exp_kind = K_DRD; exp_idle = 0;
                        end else if (acia_st[1] && !m_txr) begin
                            exp_kind = K_DWR; exp_idle = 0;
                        end else begin
                            exp_kind = K_STAT; exp_idle = GAP_LEN;
                        end
                    end
                    K_DRD: begin
                        nrxv = 1'b1;
                        nrxd = acia_rd;
                        if (rdrf) line_idx++;
                        exp_kind = K_STAT; exp_idle = GAP_LEN;
                    end
                    default: begin
                        chk("tx_bus", 32'(bus_w), 32'(m_txd));
                        ntxr = 1'b1;
                        tdre_timer = $urandom_range(1, SETTLE + 3);
                        exp_kind = K_STAT; exp_idle = SETTLE + GAP_LEN;
                    end
                endcase
            end else begin
                idle_cnt++;
                if (exp_kind != K_ANY && idle_cnt > exp_idle) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL access_timeout: idle %0d cycles, want next access after %0d", idle_cnt, exp_idle);
                    exp_kind = K_ANY;
                end
            end
            if (tdre_timer > 0 && kind != K_DWR) tdre_timer--;
            m_rxv = nrxv; m_rxd = nrxd; m_txr = ntxr; m_txd = ntxd; m_stat = nstat;
        end
    end

    task automatic wait_for(input int cond, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            case (cond)
                W_WRITE: ok = hif.write_out;
                W_RXV:   ok = hif.rx_valid_out;
                W_DWR:   ok = hif.write_out && hif.mode_out;
                W_DACC:  ok = hif.mode_out && (hif.read_out || hif.write_out);
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event within %0d cycles, want event", name, budget);
        end
    endtask

    task automatic host_take();
        @(posedge clk); #1 hif.rx_ready_in = 1'b1;
        @(posedge clk); #1 hif.rx_ready_in = 1'b0;
    endtask

    task automatic host_send(input logic [7:0] b);
        @(posedge clk); #1 hif.tx_valid_in = 1'b1; hif.tx_data_in = b;
        @(posedge clk); #1 hif.tx_valid_in = 1'b0;
    endtask

    initial begin : stim
        bit ok;
        int idle;
        hif.rx_ready_in = 1'b0;
        hif.tx_valid_in = 1'b0;
        hif.tx_data_in  = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Control write is the first access.
        wait_for(W_WRITE, 10, "first_write", ok);
        chk("first_mode", 32'(hif.mode_out), 32'h0);
        chk("first_bus", 32'(bus_w), 32'h00);

        // Single RX byte.
        @(posedge clk); #1 line_bytes.push_back(8'h41);
        wait_for(W_RXV, 50, "rx41_wait", ok);
        chk("rx41_data", 32'(hif.rx_data_out), 32'h41);
        host_take();
        @(negedge clk);
        chk("rx41_taken", 32'(hif.rx_valid_out), 32'h0);

        // Backpressure: second byte must stay in the ACIA until handshake.
        @(posedge clk); #1 line_bytes.push_back(8'h31); line_bytes.push_back(8'h32);
        wait_for(W_RXV, 50, "rx31_wait", ok);
        chk("rx31_data", 32'(hif.rx_data_out), 32'h31);
        repeat (20) @(negedge clk);
        #2;
        chk("rx31_held_valid", 32'(hif.rx_valid_out), 32'h1);
        chk("rx31_held_data", 32'(hif.rx_data_out), 32'h31);
        chk("rx32_in_acia", 32'(line_bytes.size() - line_idx), 32'h1);
        host_take();
        @(negedge clk);
        chk("rx31_taken", 32'(hif.rx_valid_out), 32'h0);
        wait_for(W_RXV, 50, "rx32_wait", ok);
        chk("rx32_data", 32'(hif.rx_data_out), 32'h32);
        host_take();

        // TX byte and settle interval before the next status read.
        host_send(8'h5A);
        wait_for(W_DWR, 50, "tx5a_wait", ok);
        chk("tx5a_bus", 32'(bus_w), 32'h5A);
        idle = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hif.read_out || hif.write_out) break;
            idle++;
        end
        chk("tx5a_settle_idle", 32'(idle), 32'(SETTLE + GAP_LEN));
        chk("tx5a_next_is_stat", 32'(hif.read_out && !hif.mode_out), 32'h1);

        // RDRF and TDRE together: RX first, held TX byte on a later poll.
        @(posedge clk); #1 rx_hold = 1'b1; tdre_hold = 1'b1; line_bytes.push_back(8'h55);
        host_send(8'h20);
        repeat (6) @(posedge clk);
        #1 rx_hold = 1'b0; tdre_hold = 1'b0;
        wait_for(W_DACC, 20, "both_first", ok);
        chk("both_first_is_read", 32'(hif.read_out), 32'h1);
        chk("both_status_bits", 32'(hif.status_out[1:0]), 32'h3);
        wait_for(W_DWR, 40, "both_tx", ok);
        chk("both_tx_bus", 32'(bus_w), 32'h20);
        chk("both_rx_data", 32'(hif.rx_data_out), 32'h55);
        host_take();

        // Reset in the middle of a data write.
        host_send(8'h7E);
        wait_for(W_DWR, 50, "rst_wdat_wait", ok);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_write", 32'(hif.write_out), 32'h0);
        chk("rst_mid_mode", 32'(hif.mode_out), 32'h0);
        chk("rst_mid_read", 32'(hif.read_out), 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_tx_ready", 32'(hif.tx_ready_out), 32'h1);
        @(posedge clk); #2 rst = 1'b0;

        // Random host traffic: heavy RX backpressure first, then mostly ready.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            hif.rx_ready_in = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            hif.tx_valid_in = ($urandom_range(0, 2) == 0);
            hif.tx_data_in  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) line_bytes.push_back(8'($urandom));
        end

        // Drain everything still pending.
        @(posedge clk); #1 hif.rx_ready_in = 1'b1; hif.tx_valid_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #2;
            ok = (line_idx == line_bytes.size()) && !hif.rx_valid_out && hif.tx_ready_out;
        end
        chk("drain_rx_pending", 32'(line_bytes.size() - line_idx), 32'h0);
        chk("drain_rx_valid", 32'(hif.rx_valid_out), 32'h0);
        chk("drain_tx_ready", 32'(hif.tx_ready_out), 32'h1);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
